// File: rtl/uart_rx_core.sv
// UART receiver core: synchronises the serial input, times bits with the shared
// baud_edge / uart_baud / sub-bit divider scheme, assembles 8N1 or 8+9th+1
// frames and reports the result with a data-valid pulse and sticky status flags.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2,
  parameter int BAUD_W      = 16
) (
  input  logic              uart_clk,
  input  logic              sys_rstn,
  input  logic              uart_en,
  input  logic              baud_edge,
  input  logic [BAUD_W-1:0] uart_baud,
  input  logic              uart_div_sel,
  input  logic              uart_prty_en,
  input  logic              uart_rx,
  input  logic              rx_pnd_clr,
  output logic [7:0]        rxbuf,
  output logic              rx_9bit,
  output logic              rx_valid,
  output logic              rx_pnd,
  output logic              rx_ferr,
  output logic              rx_ovr,
  output logic              rx_busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_NINTH = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  rx_state_e              state_r;
  rx_state_e              state_nx_s;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  logic                   rx_dly_r;
  logic [BAUD_W-1:0]      baud_cnt_r;
  logic [1:0]             sub_cnt_r;
  logic [2:0]             bit_idx_r;
  logic [7:0]             shift_r;
  logic                   ninth_r;

  logic [7:0]             rxbuf_r;
  logic                   rx_9bit_r;
  logic                   rx_valid_r;
  logic                   rx_pnd_r;
  logic                   rx_ferr_r;
  logic                   rx_ovr_r;
  logic                   rx_busy_r;

  logic                   samp_tick_s;
  logic [1:0]             smax_s;
  logic [1:0]             smid_s;
  logic                   mid_s;
  logic                   bit_end_s;
  logic                   fall_s;
  logic                   done_s;
  logic                   cnt_clr_s;

  // Timing decode: sample tick, mid-bit sample point and end-of-bit point.
  assign rx_s        = sync_r[SYNC_STAGES-1];
  assign samp_tick_s = baud_edge & (baud_cnt_r == uart_baud);
  assign smax_s      = uart_div_sel ? 2'd2 : 2'd3;
  assign smid_s      = uart_div_sel ? 2'd1 : 2'd2;
  assign mid_s       = samp_tick_s & (sub_cnt_r == smid_s);
  assign bit_end_s   = samp_tick_s & (sub_cnt_r == smax_s);
  assign fall_s      = rx_dly_r & ~rx_s;
  assign cnt_clr_s   = ~uart_en | (state_r == ST_IDLE);
  // A frame completes at the middle of the stop bit so back-to-back frames keep their start edge.
  assign done_s      = uart_en & (state_r == ST_STOP) & mid_s;

  // Input synchroniser chain plus one-cycle delayed copy for start-edge detection.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_r   <= {SYNC_STAGES{1'b1}};
      rx_dly_r <= 1'b1;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], uart_rx};
      rx_dly_r <= rx_s;
    end
  end

  // Baud counter and sub-bit counter; both held at zero while idle or disabled.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      baud_cnt_r <= {BAUD_W{1'b0}};
      sub_cnt_r  <= 2'd0;
    end else if (cnt_clr_s) begin
      baud_cnt_r <= {BAUD_W{1'b0}};
      sub_cnt_r  <= 2'd0;
    end else if (samp_tick_s) begin
      baud_cnt_r <= {BAUD_W{1'b0}};
      sub_cnt_r  <= bit_end_s ? 2'd0 : (sub_cnt_r + 2'd1);
    end else if (baud_edge) begin
      baud_cnt_r <= baud_cnt_r + {{(BAUD_W-1){1'b0}}, 1'b1};
    end
  end

  // Receive FSM state register.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Receive FSM next-state logic; disabling the receiver always forces IDLE.
  always_comb begin
    state_nx_s = state_r;
    if (!uart_en) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            state_nx_s = ST_START;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (mid_s && rx_s) begin
            state_nx_s = ST_IDLE;
          end else if (bit_end_s) begin
            state_nx_s = ST_DATA;
          end else begin
            state_nx_s = ST_START;
          end
        end
        ST_DATA: begin
          if (bit_end_s && (bit_idx_r == 3'd7)) begin
            state_nx_s = uart_prty_en ? ST_NINTH : ST_STOP;
          end else begin
            state_nx_s = ST_DATA;
          end
        end
        ST_NINTH: begin
          if (bit_end_s) begin
            state_nx_s = ST_STOP;
          end else begin
            state_nx_s = ST_NINTH;
          end
        end
        ST_STOP: begin
          if (mid_s) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_STOP;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Frame datapath: bit index, LSB-first data shift register and 9th-bit capture.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      ninth_r   <= 1'b0;
    end else if (uart_en) begin
      case (state_r)
        ST_START: begin
          if (bit_end_s) begin
            bit_idx_r <= 3'd0;
            ninth_r   <= 1'b0;
          end
        end
        ST_DATA: begin
          if (mid_s) begin
            shift_r <= {rx_s, shift_r[7:1]};
          end
          if (bit_end_s) begin
            bit_idx_r <= bit_idx_r + 3'd1;
          end
        end
        ST_NINTH: begin
          if (mid_s) begin
            ninth_r <= rx_s;
          end
        end
        default: begin
          ninth_r <= ninth_r;
        end
      endcase
    end
  end

  // Result registers and sticky flags; a flag set in the same cycle as a clear wins.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rxbuf_r    <= 8'd0;
      rx_9bit_r  <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_pnd_r   <= 1'b0;
      rx_ferr_r  <= 1'b0;
      rx_ovr_r   <= 1'b0;
      rx_busy_r  <= 1'b0;
    end else begin
      rx_valid_r <= done_s;
      rx_busy_r  <= (state_nx_s != ST_IDLE);
      if (done_s) begin
        rxbuf_r   <= shift_r;
        rx_9bit_r <= uart_prty_en & ninth_r;
      end
      if (done_s) begin
        rx_pnd_r <= 1'b1;
      end else if (rx_pnd_clr) begin
        rx_pnd_r <= 1'b0;
      end
      if (done_s && !rx_s) begin
        rx_ferr_r <= 1'b1;
      end else if (rx_pnd_clr) begin
        rx_ferr_r <= 1'b0;
      end
      if (done_s && rx_pnd_r && !rx_pnd_clr) begin
        rx_ovr_r <= 1'b1;
      end else if (rx_pnd_clr) begin
        rx_ovr_r <= 1'b0;
      end
    end
  end

  assign rxbuf    = rxbuf_r;
  assign rx_9bit  = rx_9bit_r;
  assign rx_valid = rx_valid_r;
  assign rx_pnd   = rx_pnd_r;
  assign rx_ferr  = rx_ferr_r;
  assign rx_ovr   = rx_ovr_r;
  assign rx_busy  = rx_busy_r;

endmodule
